alu_addlogic_unit: RTL and testbench

//   Registered 32-bit arithmetic/logic slice: ADD, bitwise AND, bitwise OR.

---
 rtl/alu_addlogic_unit_if.sv | 24 ++
 rtl/alu_addlogic_unit.sv | 78 +++++++
 tb/tb_alu_addlogic_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_addlogic_unit_if.sv
// Issue/result bundle between the register-file read stage and the ADD/AND/OR slice.
// The master issues operands and control; the slave returns the registered result and flags.
interface alu_addlogic_unit_if;
    logic        in_valid;
    logic [1:0]  op;
    logic        sbit;
    logic [2:0]  srcontrol;
    logic [4:0]  shamt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        out_valid;

    modport master (
        output in_valid, op, sbit, srcontrol, shamt, in1, in2,
        input  result, flags, out_valid
    );

    modport slave (
        input  in_valid, op, sbit, srcontrol, shamt, in1, in2,
        output result, flags, out_valid
    );
endinterface

// File: rtl/alu_addlogic_unit.sv
// Registered 32-bit ADD/AND/OR slice with a shift/rotate modifier on operand B.
// Flags are kept as {N,Z,C,V}, and the result is available one cycle after issue.
module alu_addlogic_unit (
    input  logic             clk,
    input  logic             reset,
    alu_addlogic_unit_if.slave bus
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_NOP = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        MOD_LSR = 3'b001,
        MOD_LSL = 3'b010,
        MOD_ROR = 3'b011
    } mod_t;

    logic [31:0] b_operand;
    logic [63:0] rot_wide;
    logic [32:0] sum;
    logic [31:0] next_result;
    logic [3:0]  next_flags;
    op_t         op_dec;

    assign op_dec = op_t'(bus.op);

    always_comb begin
        b_operand = bus.in2;
        rot_wide  = {bus.in2, bus.in2} >> bus.shamt;
        case (bus.srcontrol)
            MOD_LSR: b_operand = bus.in2 >> bus.shamt;
            MOD_LSL: b_operand = bus.in2 << bus.shamt;
            MOD_ROR: b_operand = rot_wide[31:0];
            default: b_operand = bus.in2;
        endcase
    end

    assign sum = {1'b0, bus.in1} + {1'b0, b_operand};

    // AND/OR have no carry or overflow, so C and V carry over from the last flag write.
    always_comb begin
        next_result = bus.result;
        next_flags  = bus.flags;
        case (op_dec)
            OP_ADD: begin
                next_result   = sum[31:0];
                next_flags[1] = sum[32];
                next_flags[0] = (bus.in1[31] == b_operand[31]) && (sum[31] != bus.in1[31]);
            end
            OP_AND:  next_result = bus.in1 & b_operand;
            OP_OR:   next_result = bus.in1 | b_operand;
            default: next_result = bus.result;
        endcase
        next_flags[3] = next_result[31];
        next_flags[2] = (next_result == 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.result    <= 32'd0;
            bus.flags     <= 4'b0000;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid && op_dec != OP_NOP) begin
                bus.result <= next_result;
                if (bus.sbit) begin
                    bus.flags <= next_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_addlogic_unit.sv
// Directed-vector bench for alu_addlogic_unit: expected responses are queued at issue
// and a separate monitor compares them whenever the DUT pulses out_valid.
module tb_alu_addlogic_unit;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic [3:0]  flags;
    } expect_t;

    logic clk;
    logic reset;
    int   checks;
    int   miscompares;
    expect_t exp_q[$];

    alu_addlogic_unit_if bus ();

    alu_addlogic_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one issue on the falling edge and queues its hand-computed outcome.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic sbit,
                                 input logic [2:0] src, input logic [4:0] shamt,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_result, input logic [3:0] exp_flags);
        expect_t e;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.sbit      = sbit;
        bus.srcontrol = src;
        bus.shamt     = shamt;
        bus.in1       = a;
        bus.in2       = b;
        e.name   = name;
        e.result = exp_result;
        e.flags  = exp_flags;
        exp_q.push_back(e);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in1      = 32'hDEADBEEF;
        bus.in2      = 32'hCAFEF00D;
    endtask

    task automatic checkIdle(input string name, input logic [31:0] exp_result, input logic [3:0] exp_flags);
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"},  {31'd0, bus.out_valid}, 32'd0);
        checkOutput({name, "_result"}, bus.result, exp_result);
        checkOutput({name, "_flags"},  {28'd0, bus.flags}, {28'd0, exp_flags});
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no pending issue");
            end else begin
                expect_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_result"}, bus.result, e.result);
                checkOutput({e.name, "_flags"},  {28'd0, bus.flags}, {28'd0, e.flags});
            end
        end
    end

    initial begin
        checks        = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.sbit      = 1'b0;
        bus.srcontrol = 3'b000;
        bus.shamt     = 5'd0;
        bus.in1       = 32'd0;
        bus.in2       = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_flags",  {28'd0, bus.flags}, 32'd0);
        checkOutput("reset_valid",  {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("add_noflags", 2'b00, 1'b0, 3'b000, 5'd0, 32'd5, 32'd7, 32'd12, 4'b0000);
        applyStimulus("add_wrap",    2'b00, 1'b1, 3'b000, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0110);
        applyStimulus("add_ovf",     2'b00, 1'b1, 3'b000, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001);
        applyStimulus("and_lsl",     2'b01, 1'b0, 3'b010, 5'd8, 32'hF0F0F0F0, 32'h0000FFFF, 32'h00F0F000, 4'b1001);
        applyStimulus("or_ror",      2'b10, 1'b1, 3'b011, 5'd4, 32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0F0, 4'b1001);
        idleCycle();
        checkIdle("idle_hold", 32'hF0F0F0F0, 4'b1001);

        applyStimulus("add_lsr31",   2'b00, 1'b1, 3'b001, 5'd31, 32'd0, 32'h80000000, 32'd1, 4'b0000);
        applyStimulus("add_ror0",    2'b00, 1'b0, 3'b011, 5'd0, 32'd1, 32'h12345678, 32'h12345679, 4'b0000);
        applyStimulus("add_carry",   2'b00, 1'b1, 3'b000, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd1, 4'b0010);
        applyStimulus("or_zero_keep",2'b10, 1'b1, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 4'b0110);
        applyStimulus("nop_hold",    2'b11, 1'b1, 3'b000, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'b0110);
        applyStimulus("and_nomod",   2'b01, 1'b1, 3'b111, 5'd8, 32'hFFFF0000, 32'h12345678, 32'h12340000, 4'b0010);

        // Issue is presented but reset lands before the capturing edge.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = 2'b00;
        bus.sbit      = 1'b1;
        bus.srcontrol = 3'b000;
        bus.in1       = 32'd1;
        bus.in2       = 32'd1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_result", bus.result, 32'd0);
        checkOutput("midreset_flags",  {28'd0, bus.flags}, 32'd0);
        checkOutput("midreset_valid",  {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b0;

        applyStimulus("add_lsl_neg", 2'b00, 1'b1, 3'b010, 5'd1, 32'h7FFFFFFF, 32'h40000000, 32'hFFFFFFFF, 4'b1000);
        idleCycle();
        checkIdle("final_idle", 32'hFFFFFFFF, 4'b1000);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
